// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with write bypass and pending-write scoreboard
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_RD*ADDR_W-1:0]   i_RAddr,
  output logic [N_RD*DATA_W-1:0]   o_RData,
  output logic [N_RD-1:0]          o_RBusy,
  input  logic                     i_WEn0,
  input  logic [ADDR_W-1:0]        i_WAddr0,
  input  logic [DATA_W-1:0]        i_WData0,
  input  logic                     i_WEn1,
  input  logic [ADDR_W-1:0]        i_WAddr1,
  input  logic [DATA_W-1:0]        i_WData1,
  input  logic                     i_RsvEn,
  input  logic [ADDR_W-1:0]        i_RsvAddr,
  output logic [ADDR_W:0]          o_PendCnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_next;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  rsv_hit;
  logic [CNT_W-1:0]  pend_cnt;

  logic wv0, wv1, rv;
  logic set_inc, clr0, clr1;

  // Register 0 is hardwired when ZERO_REG, so it never takes writes or reservations.
  assign wv0 = i_WEn0  && !((ZERO_REG != 0) && (i_WAddr0  == '0));
  assign wv1 = i_WEn1  && !((ZERO_REG != 0) && (i_WAddr1  == '0));
  assign rv  = i_RsvEn && !((ZERO_REG != 0) && (i_RsvAddr == '0));

  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    if (wv0) wr_hit[i_WAddr0] = 1'b1;
    if (wv1) wr_hit[i_WAddr1] = 1'b1;
    if (rv)  rsv_hit[i_RsvAddr] = 1'b1;
    pend_next = rsv_hit | (pend & ~wr_hit);
  end

  // Count transitions rather than popcount; a dual write to one address clears only once.
  always_comb begin
    set_inc = rv && !pend[i_RsvAddr];
    clr0    = wv0 && pend[i_WAddr0] && !(rv && (i_RsvAddr == i_WAddr0));
    clr1    = wv1 && pend[i_WAddr1] && !(rv && (i_RsvAddr == i_WAddr1))
              && !(wv0 && (i_WAddr0 == i_WAddr1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wv0) regs[i_WAddr0] <= i_WData0;
      if (wv1) regs[i_WAddr1] <= i_WData1;
      pend     <= pend_next;
      pend_cnt <= pend_cnt + CNT_W'(set_inc) - CNT_W'(clr0) - CNT_W'(clr1);
    end
  end

  assign o_PendCnt = pend_cnt;

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    assign raddr = i_RAddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdata = regs[raddr];
      busy  = pend[raddr];
      if (BYPASS != 0) begin
        if (wv0 && (i_WAddr0 == raddr)) rdata = i_WData0;
        if (wv1 && (i_WAddr1 == raddr)) rdata = i_WData1;
        busy = pend[raddr] & ~wr_hit[raddr];
      end
      if ((ZERO_REG != 0) && (raddr == '0)) begin
        rdata = '0;
        busy  = 1'b0;
      end
    end

    assign o_RData[k*DATA_W +: DATA_W] = rdata;
    assign o_RBusy[k]                  = busy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized model-checked bench for regfile_scoreboard
module tb_regfile_scoreboard;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int N_RD     = 2;
  localparam int BYPASS   = 1;
  localparam int ZERO_REG = 1;
  localparam int DEPTH    = 2 ** ADDR_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_RD*ADDR_W-1:0] raddr;
  logic [N_RD*DATA_W-1:0] rdata;
  logic [N_RD-1:0]        rbusy;
  logic                   wen0, wen1, rsv_en;
  logic [ADDR_W-1:0]      waddr0, waddr1, rsv_addr;
  logic [DATA_W-1:0]      wdata0, wdata1;
  logic [ADDR_W:0]        pend_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  logic [DATA_W-1:0] m_regs [DEPTH];
  logic [DEPTH-1:0]  m_pend;

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_RAddr(raddr), .o_RData(rdata), .o_RBusy(rbusy),
    .i_WEn0(wen0), .i_WAddr0(waddr0), .i_WData0(wdata0),
    .i_WEn1(wen1), .i_WAddr1(waddr1), .i_WData1(wdata1),
    .i_RsvEn(rsv_en), .i_RsvAddr(rsv_addr),
    .o_PendCnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == 0);
  endfunction

  // Expected read value: hardwired zero, else newest same-cycle write (bypass), else stored.
  function automatic logic [DATA_W-1:0] exp_rdata(input logic [ADDR_W-1:0] a);
    if (is_zero(a)) return '0;
    if (BYPASS != 0 && wen1 && waddr1 == a) return wdata1;
    if (BYPASS != 0 && wen0 && waddr0 == a) return wdata0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    bit written;
    if (is_zero(a)) return 1'b0;
    written = (wen0 && waddr0 == a) || (wen1 && waddr1 == a);
    return m_pend[a] && !(BYPASS != 0 && written);
  endfunction

  // Reference model state update
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) m_regs[r] = '0;
      m_pend = '0;
    end else begin
      if (wen0 && !is_zero(waddr0)) begin m_regs[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
      if (wen1 && !is_zero(waddr1)) begin m_regs[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
      if (rsv_en && !is_zero(rsv_addr)) m_pend[rsv_addr] = 1'b1;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < N_RD; k++) begin
        check($sformatf("rdata%0d", k), 64'(rdata[k*DATA_W +: DATA_W]),
              64'(exp_rdata(raddr[k*ADDR_W +: ADDR_W])));
        check($sformatf("rbusy%0d", k), 64'(rbusy[k]), 64'(exp_busy(raddr[k*ADDR_W +: ADDR_W])));
      end
      check("pend_cnt", 64'(pend_cnt), 64'($countones(m_pend)));
    end
  end

  task automatic idle();
    rst = 1'b0; wen0 = 1'b0; wen1 = 1'b0; rsv_en = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; rsv_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_rd(input int a0, input int a1);
    raddr = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  initial begin
    idle();
    raddr = '0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    idle();
    check_en = 1'b1;

    // Reset clears a written register
    wen0 = 1'b1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    next_cycle();
    rst = 1'b1; set_rd(5, 5);
    @(negedge clk);
    check("pre_reset_read", 64'(rdata[DATA_W-1:0]), 64'h DEADBEEF);
    next_cycle();
    set_rd(5, 5);
    @(negedge clk);
    check("post_reset_read", 64'(rdata[DATA_W-1:0]), 64'h0);
    check("post_reset_cnt", 64'(pend_cnt), 64'h0);
    check("post_reset_busy", 64'(rbusy), 64'h0);

    // Zero register ignores writes and reservations
    next_cycle();
    wen0 = 1'b1; waddr0 = 0; wdata0 = 32'h1234; rsv_en = 1'b1; rsv_addr = 0; set_rd(0, 0);
    @(negedge clk);
    check("zero_read", 64'(rdata[DATA_W-1:0]), 64'h0);
    check("zero_busy", 64'(rbusy[0]), 64'h0);
    next_cycle();
    @(negedge clk);
    check("zero_cnt", 64'(pend_cnt), 64'h0);
    check("zero_read_next", 64'(rdata[DATA_W-1:0]), 64'h0);

    // Bypass
    next_cycle();
    wen0 = 1'b1; waddr0 = 7; wdata0 = 32'h11;
    next_cycle();
    wen1 = 1'b1; waddr1 = 7; wdata1 = 32'h22; set_rd(7, 7);
    @(negedge clk);
    check("bypass_same", 64'(rdata[DATA_W-1:0]), (BYPASS != 0) ? 64'h22 : 64'h11);
    next_cycle();
    @(negedge clk);
    check("bypass_next", 64'(rdata[DATA_W-1:0]), 64'h22);

    // Dual write to one address: port 1 wins
    next_cycle();
    wen0 = 1'b1; waddr0 = 9; wdata0 = 32'hAAAA;
    wen1 = 1'b1; waddr1 = 9; wdata1 = 32'hBBBB; set_rd(9, 9);
    next_cycle();
    @(negedge clk);
    check("conflict_read", 64'(rdata[DATA_W-1:0]), 64'hBBBB);

    // Scoreboard reserve / release
    next_cycle();
    rsv_en = 1'b1; rsv_addr = 3; set_rd(3, 4);
    next_cycle();
    @(negedge clk);
    check("rsv3_busy", 64'(rbusy[0]), 64'h1);
    check("rsv3_cnt", 64'(pend_cnt), 64'h1);
    next_cycle();
    wen1 = 1'b1; waddr1 = 3; wdata1 = 32'h33; rsv_en = 1'b1; rsv_addr = 4;
    next_cycle();
    @(negedge clk);
    check("rel3_busy", 64'(rbusy[0]), 64'h0);
    check("rsv4_busy", 64'(rbusy[1]), 64'h1);
    check("swap_cnt", 64'(pend_cnt), 64'h1);

    // Reserve and write the same register in one cycle
    next_cycle();
    rsv_en = 1'b1; rsv_addr = 12; wen0 = 1'b1; waddr0 = 12; wdata0 = 32'h1212; set_rd(12, 4);
    next_cycle();
    @(negedge clk);
    check("rsvwr_busy", 64'(rbusy[0]), 64'h1);
    check("rsvwr_data", 64'(rdata[DATA_W-1:0]), 64'h1212);
    check("rsvwr_cnt", 64'(pend_cnt), 64'h2);

    // Randomised run; small address window sometimes to force collisions
    for (int c = 0; c < 10000; c++) begin
      bit narrow;
      next_cycle();
      narrow   = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 999) == 0);
      wen0     = $urandom_range(0, 1);
      wen1     = ($urandom_range(0, 2) == 0);
      rsv_en   = $urandom_range(0, 1);
      waddr0   = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      waddr1   = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      rsv_addr = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      wdata0   = $urandom;
      wdata1   = $urandom;
      raddr    = narrow ? {ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3))}
                        : (N_RD*ADDR_W)'($urandom);
    end
    next_cycle();
    @(negedge clk);
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
